remote_hex_encoder: RTL and testbench

Transmit side of the joystick answer link: captures the two players' answer buttons (4 choices each), debounces them, arbitrates between players and drives the 8-bit active-low one-hot answer code onto the joystick bus that the game board decodes into choice and player. Each code is held for a fixed window and followed by an idle gap, so the decoder sees exactly one clean code per press. Sits in the remote-controller logic, directly feeding the game board's joystick input.

---
 rtl/remote_hex_encoder_if.sv | 19 +
 rtl/remote_hex_encoder.sv | 184 ++++++++++++++++++
 tb/tb_remote_hex_encoder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/remote_hex_encoder_if.sv
// Joystick answer bus: raw player buttons in, active-low one-hot answer code and status out.
interface remote_hex_encoder_if;
    logic [3:0] btn_p1;
    logic [3:0] btn_p2;
    logic [7:0] out_hex;
    logic       busy;
    logic       tx_p1;
    logic       tx_p2;

    modport master (
        output btn_p1, btn_p2,
        input  out_hex, busy, tx_p1, tx_p2
    );

    modport slave (
        input  btn_p1, btn_p2,
        output out_hex, busy, tx_p1, tx_p2
    );
endinterface

// File: rtl/remote_hex_encoder.sv
// Transmit side of the joystick answer link: synchronizes and debounces both players' buttons,
// arbitrates between them and frames each answer code as a fixed hold window plus idle gap.
module remote_hex_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    remote_hex_encoder_if.slave  bus
);

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    logic [7:0] raw;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] deb;
    logic [7:0] deb_q;
    logic [7:0] db_cnt [8];
    logic [7:0] rise;

    logic [1:0] pending;
    logic [1:0] choice_p1;
    logic [1:0] choice_p2;
    logic       press_p1;
    logic       press_p2;
    logic       grant_p1;
    logic       grant_p2;

    state_t     state;
    logic [7:0] timer;
    logic       last_served_p2;

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] index4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    assign raw = {bus.btn_p2, bus.btn_p1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level flips only after DEBOUNCE_CYCLES disagreeing samples in a row; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise     = deb & ~deb_q;
    assign press_p1 = one_hot4(rise[3:0]);
    assign press_p2 = one_hot4(rise[7:4]);

    always_comb begin
        grant_p1 = 1'b0;
        grant_p2 = 1'b0;
        if (state == IDLE) begin
            if (pending[0] && pending[1]) begin
                grant_p1 = last_served_p2;
                grant_p2 = ~last_served_p2;
            end else begin
                grant_p1 = pending[0];
                grant_p2 = pending[1];
            end
        end
    end

    // A new press in the same cycle as a grant keeps the player pending with the newer choice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            choice_p1 <= '0;
            choice_p2 <= '0;
        end else begin
            if (press_p1) begin
                pending[0] <= 1'b1;
                choice_p1  <= index4(rise[3:0]);
            end else if (grant_p1) begin
                pending[0] <= 1'b0;
            end
            if (press_p2) begin
                pending[1] <= 1'b1;
                choice_p2  <= index4(rise[7:4]);
            end else if (grant_p2) begin
                pending[1] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            last_served_p2 <= 1'b1;
            bus.out_hex    <= 8'hFF;
            bus.busy       <= 1'b0;
            bus.tx_p1      <= 1'b0;
            bus.tx_p2      <= 1'b0;
        end else begin
            bus.tx_p1 <= 1'b0;
            bus.tx_p2 <= 1'b0;
            case (state)
                IDLE: begin
                    bus.out_hex <= 8'hFF;
                    timer       <= '0;
                    if (grant_p1) begin
                        bus.out_hex    <= ~(8'h80 >> choice_p1);
                        bus.tx_p1      <= 1'b1;
                        bus.busy       <= 1'b1;
                        last_served_p2 <= 1'b0;
                        state          <= HOLD;
                    end else if (grant_p2) begin
                        bus.out_hex    <= ~(8'h08 >> choice_p2);
                        bus.tx_p2      <= 1'b1;
                        bus.busy       <= 1'b1;
                        last_served_p2 <= 1'b1;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    if (timer == HOLD_LAST) begin
                        bus.out_hex <= 8'hFF;
                        timer       <= '0;
                        state       <= GAP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        bus.busy <= 1'b0;
                        timer    <= '0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    bus.out_hex <= 8'hFF;
                    bus.busy    <= 1'b0;
                    timer       <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_hex_encoder.sv
// Scoreboard bench for remote_hex_encoder: directed button vectors push expected codes,
// a monitor pops them on each tx pulse and checks code, player, latency, hold and gap length.
module tb_remote_hex_encoder;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [7:0] code;
        logic       p2;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    remote_hex_encoder_if bus();

    remote_hex_encoder #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .GAP_CYCLES     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] p1, input logic [3:0] p2);
        @(negedge clk);
        bus.btn_p1 = p1;
        bus.btn_p2 = p2;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expectCode(input logic [7:0] code, input logic p2, input int at_cyc);
        sb.push_back('{code: code, p2: p2, cyc: at_cyc});
    endtask

    task automatic waitQuiet();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("quiet_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic waitTxP1();
        int n;
        n = 0;
        while (!bus.tx_p1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("p1_start_timeout", 32'(n < 30), 32'd1);
    endtask

    task automatic checkIdleFor(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput(name, {23'd0, bus.busy, bus.out_hex}, {23'd0, 1'b0, 8'hFF});
        end
    endtask

    // Monitor: every code start is matched against the head of the scoreboard.
    initial begin
        logic [7:0] code;
        logic       p2;
        logic       aborted;
        int         n;
        int         g;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.tx_p1 || bus.tx_p2)) begin
                code = bus.out_hex;
                p2   = bus.tx_p2;
                checkOutput("tx_both", 32'(bus.tx_p1 & bus.tx_p2), 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_tx", {24'd0, code}, 32'hFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("code", {24'd0, code}, {24'd0, e.code});
                    checkOutput("player", 32'(p2), 32'(e.p2));
                    if (e.cyc >= 0) checkOutput("latency", 32'(cyc), 32'(e.cyc));
                end
                n = 1;
                @(negedge clk);
                if (!rst) checkOutput("tx_pulse", 32'(bus.tx_p1 | bus.tx_p2), 32'd0);
                while (!rst && bus.out_hex == code && n < 300) begin
                    n++;
                    @(negedge clk);
                end
                aborted = rst;
                if (!aborted) checkOutput("hold_len", 32'(n), 32'd8);
                g = 0;
                while (!rst && bus.busy && bus.out_hex == 8'hFF && g < 300) begin
                    g++;
                    @(negedge clk);
                end
                if (!aborted && !rst) checkOutput("gap_len", 32'(g), 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus.btn_p1 = 4'd0;
        bus.btn_p2 = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_hex", {24'd0, bus.out_hex}, 32'hFF);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_tx", 32'({bus.tx_p1, bus.tx_p2}), 32'd0);
        rst = 1'b0;
        checkIdleFor("post_reset_idle", 2);

        // Single press held well beyond one code frame: one code, fixed latency, no repeat.
        applyStimulus(4'b0001, 4'b0000);
        expectCode(8'h7F, 1'b0, cyc + 8);
        repeat (19) @(negedge clk);
        applyStimulus(4'b0000, 4'b0000);
        waitQuiet();
        checkIdleFor("no_repeat", 10);

        // Glitch shorter than the debounce window.
        applyStimulus(4'b0000, 4'b1000);
        repeat (2) @(negedge clk);
        applyStimulus(4'b0000, 4'b0000);
        checkIdleFor("glitch_idle", 15);

        // Tie after reset goes to P1, then P2.
        applyReset();
        expectCode(8'hBF, 1'b0, -1);
        expectCode(8'hFD, 1'b1, -1);
        applyStimulus(4'b0010, 4'b0100);
        waitQuiet();
        applyStimulus(4'b0000, 4'b0000);
        repeat (10) @(negedge clk);

        // P1 served alone, so the next tie favours P2.
        expectCode(8'hEF, 1'b0, -1);
        applyStimulus(4'b1000, 4'b0000);
        waitQuiet();
        applyStimulus(4'b0000, 4'b0000);
        repeat (10) @(negedge clk);

        expectCode(8'hFD, 1'b1, -1);
        expectCode(8'hBF, 1'b0, -1);
        applyStimulus(4'b0010, 4'b0100);
        waitQuiet();
        applyStimulus(4'b0000, 4'b0000);
        repeat (10) @(negedge clk);

        // Two P2 presses during a P1 frame: only the latest is sent.
        expectCode(8'hDF, 1'b0, -1);
        expectCode(8'hFE, 1'b1, -1);
        applyStimulus(4'b0100, 4'b0000);
        waitTxP1();
        bus.btn_p2 = 4'b0001;
        repeat (2) @(negedge clk);
        bus.btn_p2 = 4'b1001;
        waitQuiet();
        applyStimulus(4'b0000, 4'b0000);
        repeat (10) @(negedge clk);

        // Two buttons of one player rising together are ignored.
        applyStimulus(4'b1100, 4'b0000);
        checkIdleFor("double_press_idle", 15);
        applyStimulus(4'b0000, 4'b0000);
        checkIdleFor("double_release_idle", 10);

        // Reset in the middle of a code frame with a P2 press pending.
        expectCode(8'hBF, 1'b0, -1);
        applyStimulus(4'b0010, 4'b0000);
        repeat (2) @(negedge clk);
        bus.btn_p2 = 4'b0001;
        waitTxP1();
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_out_hex", {24'd0, bus.out_hex}, 32'hFF);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        bus.btn_p1 = 4'd0;
        bus.btn_p2 = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkIdleFor("after_abort_idle", 25);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
